// File: rtl/dmem_responder_pkg.sv
// Shared types for the dmem responder: bus word/line/mask types, FSM state
// encoding and the byte-enable merge helper used for write-through lines.
package lc3b_types;

  typedef logic [15:0]  lc3b_word;
  typedef logic [127:0] lc3b_data;
  typedef logic [1:0]   lc3b_mem_wmask;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY    = 2'd1,
    RESP    = 2'd2,
    REFRESH = 2'd3
  } dmem_resp_state_t;

  // Overlay the enabled bytes of new_w onto old_w.
  function automatic lc3b_word merge_bytes(lc3b_word old_w, lc3b_word new_w, lc3b_mem_wmask be);
    lc3b_word m;
    m = old_w;
    if (be[0]) m[7:0]  = new_w[7:0];
    if (be[1]) m[15:8] = new_w[15:8];
    return m;
  endfunction

endpackage

// File: rtl/dmem_responder_array.sv
// MEM_WORDS x 16-bit storage with a byte-enabled word write port and an
// asynchronous 8-word line read port. Contents are never cleared.
module dmem_resp_array
  import lc3b_types::*;
#(
  parameter int MEM_WORDS = 1024
) (
  input  logic                           clk,
  input  logic                           i_we,
  input  logic [$clog2(MEM_WORDS)-1:0]   i_waddr,
  input  lc3b_word                       i_wdata,
  input  lc3b_mem_wmask                  i_be,
  input  logic [$clog2(MEM_WORDS)-4:0]   i_rline,
  output lc3b_data                       o_rline
);

  lc3b_word r_mem [MEM_WORDS];

  // Byte-lane write of one word.
  always_ff @(posedge clk) begin
    if (i_we) begin
      if (i_be[0]) r_mem[i_waddr][7:0]  <= i_wdata[7:0];
      if (i_be[1]) r_mem[i_waddr][15:8] <= i_wdata[15:8];
    end
  end

  // Gather the 8 words of the addressed line; word k lands at [16k+15:16k].
  always_comb begin
    o_rline = '0;
    for (int k = 0; k < 8; k++) begin
      o_rline[16*k +: 16] = r_mem[{i_rline, 3'(k)}];
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Responder end of the stb/cyc data memory bus: fixed-latency line reads,
// byte-enabled word writes, one-cycle resp pulse.
// Optional refresh windows with retry are enabled by defining DMEM_RESP_REFRESH_EN;
// without it there is no refresh logic and dmem_retry is tied low.
module dmem_responder
  import lc3b_types::*;
#(
  parameter int LATENCY        = 3,
  parameter int MEM_WORDS      = 1024,
  parameter int REFRESH_PERIOD = 64,
  parameter int REFRESH_CYCLES = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          dmem_action_cyc,
  input  logic          dmem_action_stb,
  input  logic          dmem_write,
  input  lc3b_word      dmem_address,
  input  lc3b_word      dmem_wdata,
  input  lc3b_mem_wmask dmem_byte_enable,
  output lc3b_data      dmem_rdata,
  output logic          dmem_resp,
  output logic          dmem_retry
);

  localparam int AW = $clog2(MEM_WORDS);
  localparam int CW = $clog2(LATENCY + 1);

  dmem_resp_state_t r_state, w_state_nxt;
  logic [CW-1:0]    r_cnt;
  logic             r_write;
  logic [AW-1:0]    r_widx;
  lc3b_word         r_wdata;
  lc3b_mem_wmask    r_be;
  lc3b_data         r_rdata_hold;
  lc3b_data         w_line;
  lc3b_data         w_resp_line;
  logic             w_accept;
  logic             w_req;
  logic             w_ref_due;
  logic             w_ref_win_end;
  logic             w_we;
  logic             w_unused;

  assign w_req    = dmem_action_cyc & dmem_action_stb;
  assign w_accept = (r_state == IDLE) && ((w_state_nxt == BUSY) || (w_state_nxt == RESP));
  assign w_we     = (r_state == RESP) && r_write && !reset;
  assign w_unused = dmem_address[0] ^ (|(dmem_address >> (AW + 1)));

`ifdef DMEM_RESP_REFRESH_EN
  localparam int RW = $clog2(REFRESH_PERIOD);
  localparam int WW = $clog2(REFRESH_CYCLES + 1);

  logic [RW-1:0] r_ref_cnt;
  logic [WW-1:0] r_ref_win;
  logic          r_ref_due;
  logic          w_ref_start;

  assign w_ref_due     = r_ref_due;
  assign w_ref_win_end = (r_ref_win == '0);
  assign w_ref_start   = (r_state != REFRESH) && (w_state_nxt == REFRESH);

  // Free-running period counter; a pending refresh stays flagged until its window starts.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ref_cnt <= '0;
      r_ref_due <= 1'b0;
      r_ref_win <= '0;
    end else begin
      r_ref_cnt <= (r_ref_cnt == RW'(REFRESH_PERIOD - 1)) ? '0 : r_ref_cnt + 1'b1;
      if (r_ref_cnt == RW'(REFRESH_PERIOD - 1)) r_ref_due <= 1'b1;
      else if (w_ref_start)                     r_ref_due <= 1'b0;
      if (w_ref_start)                                 r_ref_win <= WW'(REFRESH_CYCLES - 1);
      else if ((r_state == REFRESH) && !w_ref_win_end) r_ref_win <= r_ref_win - 1'b1;
    end
  end
`else
  logic w_unused_ref;
  assign w_ref_due     = 1'b0;
  assign w_ref_win_end = 1'b1;
  assign w_unused_ref  = |{REFRESH_PERIOD, REFRESH_CYCLES};
`endif

  dmem_resp_array #(.MEM_WORDS(MEM_WORDS)) u_array (
    .clk     (clk),
    .i_we    (w_we),
    .i_waddr (r_widx),
    .i_wdata (r_wdata),
    .i_be    (r_be),
    .i_rline (r_widx[AW-1:3]),
    .o_rline (w_line)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state logic; a due refresh beats a simultaneous request in IDLE.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (w_ref_due)  w_state_nxt = REFRESH;
        else if (w_req) w_state_nxt = (LATENCY == 1) ? RESP : BUSY;
      end
      BUSY: begin
        if (!dmem_action_cyc)       w_state_nxt = IDLE;
        else if (r_cnt <= CW'(1))   w_state_nxt = RESP;
      end
      RESP:    w_state_nxt = w_ref_due ? REFRESH : IDLE;
      REFRESH: w_state_nxt = w_ref_win_end ? IDLE : REFRESH;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Outputs: resp only in RESP, retry only in REFRESH, rdata live in RESP and held otherwise.
  always_comb begin
    dmem_resp  = (r_state == RESP);
    dmem_retry = 1'b0;
`ifdef DMEM_RESP_REFRESH_EN
    dmem_retry = (r_state == REFRESH) && w_req;
`endif
    dmem_rdata = (r_state == RESP) ? w_resp_line : r_rdata_hold;
  end

  // Returned line reflects a pending write before it commits at the end of RESP.
  always_comb begin
    w_resp_line = w_line;
    if (r_write) begin
      w_resp_line[{r_widx[2:0], 4'b0} +: 16] =
        merge_bytes(w_line[{r_widx[2:0], 4'b0} +: 16], r_wdata, r_be);
    end
  end

  // Latency down-counter, loaded on acceptance.
  always_ff @(posedge clk) begin
    if (reset)                  r_cnt <= '0;
    else if (w_accept)          r_cnt <= CW'(LATENCY - 1);
    else if (r_state == BUSY)   r_cnt <= r_cnt - 1'b1;
  end

  // Request capture; the bus may change freely once accepted.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_write <= 1'b0;
      r_widx  <= '0;
      r_wdata <= '0;
      r_be    <= '0;
    end else if (w_accept) begin
      r_write <= dmem_write;
      r_widx  <= dmem_address[AW:1];
      r_wdata <= dmem_wdata;
      r_be    <= dmem_byte_enable;
    end
  end

  // Hold the last returned line between responses.
  always_ff @(posedge clk) begin
    if (reset)                 r_rdata_hold <= '0;
    else if (r_state == RESP)  r_rdata_hold <= w_resp_line;
  end

endmodule
